// File: rtl/affine_addr_gen.sv
// N-dimensional affine address generator: addr = offset + sum(idx[d]*stride[d]),
// dim 0 fastest, built from incremental per-dim partial sums (no multipliers).
module affine_addr_gen #(
  parameter int DIMS  = 4,
  parameter int WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [WIDTH-1:0]        offset,
  input  logic [DIMS*WIDTH-1:0]   extent,
  input  logic [DIMS*WIDTH-1:0]   stride,
  output logic                    addr_valid,
  input  logic                    addr_ready,
  output logic [WIDTH-1:0]        addr,
  output logic                    addr_last,
  output logic                    busy,
  output logic                    done
);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  state_t state, state_nxt;

  logic [WIDTH-1:0]            offset_q;
  logic [DIMS-1:0][WIDTH-1:0]  extent_q, stride_q;
  logic [DIMS-1:0][WIDTH-1:0]  idx, part;
  logic [DIMS-1:0][WIDTH-1:0]  idx_nxt, part_nxt;
  logic [DIMS-1:0]             at_max;
  logic                        all_max, any_zero, accept, xfer;
  logic [WIDTH-1:0]            sum;

  // Handshake: a beat transfers on a rising edge where addr_valid & addr_ready;
  // without a transfer addr/addr_last hold, and addr_ready is ignored while
  // addr_valid is low.
  assign accept = (state == IDLE) && start;
  assign xfer   = addr_valid && addr_ready;

  always_comb begin
    at_max = '0;
    for (int d = 0; d < DIMS; d++)
      at_max[d] = (idx[d] == extent_q[d] - 1'b1);
  end
  assign all_max = &at_max;

  always_comb begin
    any_zero = 1'b0;
    for (int d = 0; d < DIMS; d++)
      if (extent[d*WIDTH +: WIDTH] == '0) any_zero = 1'b1;
  end

  always_comb begin
    sum = offset_q;
    for (int d = 0; d < DIMS; d++)
      sum = sum + part[d];
  end

  // Carry chain: saturated dims wrap to zero until the first dim with room steps.
  always_comb begin
    logic carry;
    idx_nxt  = idx;
    part_nxt = part;
    carry    = 1'b1;
    for (int d = 0; d < DIMS; d++) begin
      if (carry) begin
        if (at_max[d]) begin
          idx_nxt[d]  = '0;
          part_nxt[d] = '0;
        end else begin
          idx_nxt[d]  = idx[d] + 1'b1;
          part_nxt[d] = part[d] + stride_q[d];
          carry       = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = any_zero ? DONE : RUN;
      RUN:     if (xfer && all_max) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    addr_valid = (state == RUN);
    busy       = (state == RUN);
    done       = (state == DONE);
    addr_last  = (state == RUN) && all_max;
    addr       = sum;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      offset_q <= '0;
      extent_q <= '0;
      stride_q <= '0;
      idx      <= '0;
      part     <= '0;
    end else if (accept) begin
      offset_q <= offset;
      extent_q <= extent;
      stride_q <= stride;
      idx      <= '0;
      part     <= '0;
    end else if (xfer && !all_max) begin
      idx  <= idx_nxt;
      part <= part_nxt;
    end
  end

endmodule
